// File: rtl/garduino_sensor_pkg.sv
// rtl/garduino_sensor_pkg.sv - register map constants for the greenhouse sensor port
package garduino_sensor_pkg;

    localparam logic [3:0] ADDR_FLAGS   = 4'd0;
    localparam logic [3:0] ADDR_MASK    = 4'd1;
    localparam logic [3:0] ADDR_THRESH  = 4'd2;
    localparam logic [3:0] ADDR_CTRL    = 4'd3;
    localparam logic [3:0] ADDR_CH_BASE = 4'd4;

    localparam int CTRL_FREEZE_BIT = 0;

endpackage

// File: rtl/garduino_sensor_chan.sv
// rtl/garduino_sensor_chan.sv - one sensor channel: optional block average, snapshot, threshold change detect
// Averaging is built only when GARDUINO_SENSOR_AVG_EN is defined.
module garduino_sensor_chan
    import garduino_sensor_pkg::*;
#(
    parameter int CH_W     = 8,
    parameter int AVG_LOG2 = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick_i,
    input  logic            last_i,
    input  logic [CH_W-1:0] sample_i,
    input  logic [CH_W-1:0] thresh_i,
    input  logic            freeze_i,
    output logic [CH_W-1:0] s_o,
    output logic            set_o
);

    logic [CH_W-1:0] f_new;
    logic            upd;
    logic [CH_W-1:0] ref_q, ref_d;
    logic [CH_W-1:0] s_q, s_d;
    logic            set_q, set_d;
    logic [CH_W:0]   a_ext, b_ext, diff;
    logic            hit;

`ifdef GARDUINO_SENSOR_AVG_EN
    localparam int ACC_W = CH_W + AVG_LOG2;

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;

    // The sum including the current sample is never wider than ACC_W bits.
    assign acc_sum = acc_q + ACC_W'(sample_i);
    assign f_new   = acc_sum[ACC_W-1:AVG_LOG2];
    assign upd     = tick_i & last_i;

    always_comb begin
        acc_d = acc_q;
        if (tick_i) begin
            acc_d = last_i ? '0 : acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    localparam int unused_avg_log2 = AVG_LOG2;

    assign f_new = sample_i;
    assign upd   = tick_i & last_i;
`endif

    // One extra bit keeps the absolute difference free of wrap-around.
    assign a_ext = {1'b0, f_new};
    assign b_ext = {1'b0, ref_q};
    assign diff  = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
    assign hit   = (thresh_i != '0) && (diff >= {1'b0, thresh_i});

    always_comb begin
        ref_d = ref_q;
        s_d   = s_q;
        set_d = 1'b0;
        if (upd) begin
            if (!freeze_i) begin
                s_d = f_new;
            end
            if (hit) begin
                ref_d = f_new;
                set_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_q <= '0;
            s_q   <= '0;
            set_q <= 1'b0;
        end else begin
            ref_q <= ref_d;
            s_q   <= s_d;
            set_q <= set_d;
        end
    end

    assign s_o   = s_q;
    assign set_o = set_q;

endmodule

// File: rtl/garduino_sensor_pio.sv
// rtl/garduino_sensor_pio.sv - Avalon-MM sensor input port with sampling, change flags and irq
// Optional per-channel block averaging is enabled by defining GARDUINO_SENSOR_AVG_EN.
module garduino_sensor_pio
    import garduino_sensor_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 8,
    parameter int SAMPLE_DIV = 1000,
    parameter int AVG_LOG2   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             address,
    input  logic                   chipselect,
    input  logic                   write,
    input  logic [31:0]            writedata,
    output logic [31:0]            readdata,
    input  logic [NUM_CH*CH_W-1:0] in_port,
    output logic                   irq
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [NUM_CH*CH_W-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   tick;
    logic                   blk_last;
    logic [NUM_CH-1:0]      flags_q, flags_d;
    logic [NUM_CH-1:0]      mask_q, mask_d;
    logic [CH_W-1:0]        thresh_q, thresh_d;
    logic                   freeze_q, freeze_d;
    logic [31:0]            readdata_q, readdata_d;
    logic                   irq_q;
    logic [NUM_CH-1:0]      set_vec;
    logic [NUM_CH*CH_W-1:0] s_bus;
    logic                   wr;
    logic                   unused_wd;

    assign wr        = chipselect & write;
    assign tick      = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign unused_wd = ^writedata;

`ifdef GARDUINO_SENSOR_AVG_EN
    localparam int BLK_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [BLK_W-1:0] blk_q;

    assign blk_last = (blk_q == BLK_W'((1 << AVG_LOG2) - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q <= '0;
        end else if (tick) begin
            blk_q <= blk_last ? '0 : blk_q + 1'b1;
        end
    end
`else
    assign blk_last = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        garduino_sensor_chan #(
            .CH_W     (CH_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .tick_i   (tick),
            .last_i   (blk_last),
            .sample_i (sync2_q[g*CH_W +: CH_W]),
            .thresh_i (thresh_q),
            .freeze_i (freeze_q),
            .s_o      (s_bus[g*CH_W +: CH_W]),
            .set_o    (set_vec[g])
        );
    end

    // A flag set arriving with a W1C of the same bit wins over the clear.
    always_comb begin
        flags_d  = flags_q;
        mask_d   = mask_q;
        thresh_d = thresh_q;
        freeze_d = freeze_q;
        if (wr) begin
            case (address)
                ADDR_FLAGS:  flags_d  = flags_q & ~writedata[NUM_CH-1:0];
                ADDR_MASK:   mask_d   = writedata[NUM_CH-1:0];
                ADDR_THRESH: thresh_d = writedata[CH_W-1:0];
                ADDR_CTRL:   freeze_d = writedata[CTRL_FREEZE_BIT];
                default:     ;
            endcase
        end
        flags_d = flags_d | set_vec;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_FLAGS:  readdata_d[NUM_CH-1:0]      = flags_q;
            ADDR_MASK:   readdata_d[NUM_CH-1:0]      = mask_q;
            ADDR_THRESH: readdata_d[CH_W-1:0]        = thresh_q;
            ADDR_CTRL:   readdata_d[CTRL_FREEZE_BIT] = freeze_q;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (address == ADDR_CH_BASE + 4'(i)) begin
                        readdata_d[CH_W-1:0] = s_bus[i*CH_W +: CH_W];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cnt_q      <= '0;
            flags_q    <= '0;
            mask_q     <= '0;
            thresh_q   <= '0;
            freeze_q   <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            cnt_q      <= tick ? '0 : cnt_q + 1'b1;
            flags_q    <= flags_d;
            mask_q     <= mask_d;
            thresh_q   <= thresh_d;
            freeze_q   <= freeze_d;
            readdata_q <= readdata_d;
            irq_q      <= |(flags_q & mask_q);
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
